// File: rtl/param_forwarding_unit_pkg.sv
// Shared definitions for the operand-forwarding / load-use hazard unit.
package param_forwarding_unit_pkg;

  // Hazard FSM: RUN forwards freely, STALL waits for a late producer
  typedef enum logic [0:0] {
    FWD_RUN   = 1'b0,
    FWD_STALL = 1'b1
  } fwd_state_e;

  // Producer stage indices, youngest first
  localparam int STG_EXE = 0;
  localparam int STG_MEM = 1;

endpackage

// File: rtl/param_forwarding_unit_fwd_select.sv
// Priority match of one operand against all producer stages.
// The youngest matching stage wins. With code_chk_i low the register code is
// ignored and only en_i/wen_i decide, which is how HI and LO are resolved.
module param_forwarding_unit_fwd_select
  import param_forwarding_unit_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int RADDR_W    = 5,
  parameter int NUM_STAGES = 2
) (
  input  logic                          en_i,
  input  logic                          code_chk_i,
  input  logic [RADDR_W-1:0]            code_i,
  input  logic [NUM_STAGES-1:0]         wen_i,
  input  logic [NUM_STAGES-1:0]         ready_i,
  input  logic [NUM_STAGES*RADDR_W-1:0] rcode_i,
  input  logic [NUM_STAGES*DATA_W-1:0]  rdata_i,
  output logic                          hit_o,
  output logic                          ready_o,
  output logic [DATA_W-1:0]             data_o
);

  // Walk from oldest to youngest so the youngest match overwrites the rest
  always_comb begin
    hit_o   = 1'b0;
    ready_o = 1'b0;
    data_o  = '0;
    for (int k = NUM_STAGES - 1; k >= STG_EXE; k--) begin
      if (en_i && wen_i[k] &&
          (!code_chk_i ||
           ((rcode_i[k*RADDR_W +: RADDR_W] == code_i) && (code_i != '0)))) begin
        hit_o   = 1'b1;
        ready_o = ready_i[k];
        data_o  = rdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/param_forwarding_unit.sv
// Operand forwarding and load-use hazard unit beside the ID stage.
// All outputs are registered on the falling clock edge so ID can use them in
// the second half of the same cycle. A not-ready producer holds ID in STALL
// until every pending operand can be forwarded; overly long stalls raise a
// sticky stall_err. HI/LO forwarding never stalls.
module param_forwarding_unit
  import param_forwarding_unit_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int RADDR_W    = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int MAX_STALL  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_SRC-1:0]            id_rd_en,
  input  logic [NUM_SRC*RADDR_W-1:0]    id_rcode,
  input  logic                          id_mfhi,
  input  logic                          id_mflo,
  input  logic [NUM_STAGES-1:0]         st_wen,
  input  logic [NUM_STAGES-1:0]         st_ready,
  input  logic [NUM_STAGES*RADDR_W-1:0] st_rcode,
  input  logic [NUM_STAGES*DATA_W-1:0]  st_rdata,
  input  logic [NUM_STAGES-1:0]         st_hi_wen,
  input  logic [NUM_STAGES-1:0]         st_lo_wen,
  input  logic [NUM_STAGES*DATA_W-1:0]  st_hi,
  input  logic [NUM_STAGES*DATA_W-1:0]  st_lo,
  output logic                          stall,
  output logic                          stall_err,
  output logic [NUM_SRC-1:0]            fwd_en,
  output logic [NUM_SRC*DATA_W-1:0]     fwd_data,
  output logic                          hi_fwd_en,
  output logic                          lo_fwd_en,
  output logic [DATA_W-1:0]             hi_data_out,
  output logic [DATA_W-1:0]             lo_data_out
);

  localparam int CNT_W = $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_SRC-1:0]        src_hit, src_rdy, not_ready;
  logic [DATA_W-1:0]         src_data [NUM_SRC];
  logic                      hi_hit, hi_rdy, lo_hit, lo_rdy;
  logic [DATA_W-1:0]         hi_sel, lo_sel;

  fwd_state_e                state_q, state_d;
  logic                      stall_q, stall_d;
  logic                      err_q, err_d;
  logic [NUM_SRC-1:0]        pend_q, pend_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_SRC-1:0]        fwd_en_q, fwd_en_d;
  logic [NUM_SRC*DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic                      hi_en_q, hi_en_d, lo_en_q, lo_en_d;
  logic [DATA_W-1:0]         hi_data_q, hi_data_d, lo_data_q, lo_data_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    param_forwarding_unit_fwd_select #(
      .DATA_W(DATA_W), .RADDR_W(RADDR_W), .NUM_STAGES(NUM_STAGES)
    ) u_sel (
      .en_i      (id_rd_en[i]),
      .code_chk_i(1'b1),
      .code_i    (id_rcode[i*RADDR_W +: RADDR_W]),
      .wen_i     (st_wen),
      .ready_i   (st_ready),
      .rcode_i   (st_rcode),
      .rdata_i   (st_rdata),
      .hit_o     (src_hit[i]),
      .ready_o   (src_rdy[i]),
      .data_o    (src_data[i])
    );
  end

  param_forwarding_unit_fwd_select #(
    .DATA_W(DATA_W), .RADDR_W(RADDR_W), .NUM_STAGES(NUM_STAGES)
  ) u_hi_sel (
    .en_i      (id_mfhi),
    .code_chk_i(1'b0),
    .code_i    ('0),
    .wen_i     (st_hi_wen),
    .ready_i   ({NUM_STAGES{1'b1}}),
    .rcode_i   ('0),
    .rdata_i   (st_hi),
    .hit_o     (hi_hit),
    .ready_o   (hi_rdy),
    .data_o    (hi_sel)
  );

  param_forwarding_unit_fwd_select #(
    .DATA_W(DATA_W), .RADDR_W(RADDR_W), .NUM_STAGES(NUM_STAGES)
  ) u_lo_sel (
    .en_i      (id_mflo),
    .code_chk_i(1'b0),
    .code_i    ('0),
    .wen_i     (st_lo_wen),
    .ready_i   ({NUM_STAGES{1'b1}}),
    .rcode_i   ('0),
    .rdata_i   (st_lo),
    .hit_o     (lo_hit),
    .ready_o   (lo_rdy),
    .data_o    (lo_sel)
  );

  assign not_ready = src_hit & ~src_rdy;

  // Next-state: forwarding choices, stall entry/release, timeout and flush
  always_comb begin
    state_d    = state_q;
    stall_d    = stall_q;
    err_d      = err_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    fwd_data_d = fwd_data_q;
    hi_data_d  = hi_data_q;
    lo_data_d  = lo_data_q;
    fwd_en_d   = flush ? '0 : (src_hit & src_rdy);
    hi_en_d    = hi_hit & hi_rdy;
    lo_en_d    = lo_hit & lo_rdy;

    for (int i = 0; i < NUM_SRC; i++) begin
      if (fwd_en_d[i]) fwd_data_d[i*DATA_W +: DATA_W] = src_data[i];
    end
    if (hi_en_d) hi_data_d = hi_sel;
    if (lo_en_d) lo_data_d = lo_sel;

    if (flush) begin
      state_d = FWD_RUN;
      stall_d = 1'b0;
      pend_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        FWD_RUN: begin
          if (|not_ready) begin
            state_d = FWD_STALL;
            stall_d = 1'b1;
            pend_d  = not_ready;
            cnt_d   = CNT_ONE;
            if (CNT_ONE >= CNT_MAX) err_d = 1'b1;
          end
        end
        FWD_STALL: begin
          if (|(pend_q & not_ready)) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            if (cnt_d == CNT_MAX) err_d = 1'b1;
          end else begin
            state_d = FWD_RUN;
            stall_d = 1'b0;
            pend_d  = '0;
            cnt_d   = '0;
          end
        end
        default: state_d = FWD_RUN;
      endcase
    end
  end

  // Falling-edge state and output registers, cleared asynchronously by reset
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= FWD_RUN;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
      pend_q     <= '0;
      cnt_q      <= '0;
      fwd_en_q   <= '0;
      fwd_data_q <= '0;
      hi_en_q    <= 1'b0;
      lo_en_q    <= 1'b0;
      hi_data_q  <= '0;
      lo_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      fwd_en_q   <= fwd_en_d;
      fwd_data_q <= fwd_data_d;
      hi_en_q    <= hi_en_d;
      lo_en_q    <= lo_en_d;
      hi_data_q  <= hi_data_d;
      lo_data_q  <= lo_data_d;
    end
  end

  assign stall       = stall_q;
  assign stall_err   = err_q;
  assign fwd_en      = fwd_en_q;
  assign fwd_data    = fwd_data_q;
  assign hi_fwd_en   = hi_en_q;
  assign lo_fwd_en   = lo_en_q;
  assign hi_data_out = hi_data_q;
  assign lo_data_out = lo_data_q;

endmodule
